// File: rtl/acc_readout_if.sv
// ============================================================================
// Module  : acc_readout_if
// Brief   : Term-stream, accumulator-control and result handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface acc_readout_if #(
  parameter int ACC_W = 14,
  parameter int CNT_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             acc_en;
  logic [ACC_W-1:0] acc_val;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_partial;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, flush, acc_val, out_ready,
    output in_ready, acc_en, acc_clr, out_valid, out_data, out_partial, out_count
  );

  modport master (
    output in_valid, flush, acc_val, out_ready,
    input  in_ready, acc_en, acc_clr, out_valid, out_data, out_partial, out_count
  );
endinterface

`default_nettype wire

// File: rtl/acc_readout.sv
// ============================================================================
// Module  : acc_readout
// Brief   : Groups accumulator terms, captures each group sum and hands it on.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_readout #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 14,
  parameter int TERMS = 16,
  parameter int CNT_W = 10
) (
  input  wire logic   clk,
  input  wire logic   reset,
  acc_readout_if.slave bus
);

  // Out-of-range TERMS is clamped to the largest group that cannot overflow.
  localparam int c_MAX_TERMS = ((2**ACC_W) - 1) / ((2**IN_W) - 1);
  localparam int c_TERMS_HI  = (TERMS > c_MAX_TERMS) ? c_MAX_TERMS : TERMS;
  localparam int c_TERMS_EFF = (c_TERMS_HI < 1) ? 1 : c_TERMS_HI;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(c_TERMS_EFF - 1);

  localparam logic [1:0] c_ACCUM   = 2'd0;
  localparam logic [1:0] c_CAPTURE = 2'd1;
  localparam logic [1:0] c_CLEAR   = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  logic             r_acc_clr;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_partial;
  logic [CNT_W-1:0] r_out_count;

  logic w_in_ready;
  logic w_strobe;
  logic w_last;
  logic w_flush_close;
  logic w_cap_ok;

  assign w_in_ready    = (r_state == c_ACCUM);
  assign w_strobe      = bus.in_valid & w_in_ready;
  assign w_last        = w_strobe && (r_cnt == c_LAST);
  assign w_flush_close = bus.flush && ((r_cnt != '0) || w_strobe);
  assign w_cap_ok      = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_ACCUM;
      r_cnt         <= '0;
      r_full        <= 1'b0;
      r_acc_clr     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_partial <= 1'b0;
      r_out_count   <= '0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        c_ACCUM: begin
          if (w_strobe) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // A completing strobe wins over a same-cycle flush: the group is full.
          if (w_last) begin
            r_full  <= 1'b1;
            r_state <= c_CAPTURE;
          end else if (w_flush_close) begin
            r_full  <= 1'b0;
            r_state <= c_CAPTURE;
          end
        end
        c_CAPTURE: begin
          if (w_cap_ok) begin
            r_out_data    <= bus.acc_val;
            r_out_count   <= r_cnt;
            r_out_partial <= !r_full;
            r_out_valid   <= 1'b1;
            r_acc_clr     <= 1'b1;
            r_state       <= c_CLEAR;
          end
        end
        c_CLEAR: begin
          r_acc_clr <= 1'b0;
          r_cnt     <= '0;
          r_state   <= c_ACCUM;
        end
        default: begin
          r_acc_clr <= 1'b0;
          r_cnt     <= '0;
          r_state   <= c_ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.acc_en      = w_strobe;
  assign bus.acc_clr     = r_acc_clr;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_partial = r_out_partial;
  assign bus.out_count   = r_out_count;

endmodule

`default_nettype wire
